cla_sub_pipe_32bit: RTL
=======================

CLA_SUB_PIPE_32BIT -- requirements
Module: cla_sub_pipe_32bit

Interface
REQ-001 Parameter WIDTH, default 32, operand width; SHALL be a multiple of 8 and at least 8.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset; SHALL be asynchronous and active-low.
REQ-004 in_valid  input  1  operand beat offered.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 A  input  WIDTH  minuend.
REQ-007 B  input  WIDTH  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result beat offered.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 Diff  output  WIDTH  A - B - bin, modulo 2^WIDTH.
REQ-012 bout  output  1  unsigned borrow-out; 1 when A < B + bin, unsigned.
REQ-013 OF  output  1  signed overflow of the subtraction.

Function
REQ-014 Arithmetic SHALL be A + ~B + ~bin, evaluated in 4-bit carry-look-ahead slices; bout SHALL equal the inverted final carry.
REQ-015 OF SHALL be 1 exactly when A[MSB] != B[MSB] and Diff[MSB] != A[MSB].
REQ-016 Two pipeline stages: stage 1 computes the low WIDTH/2 bits and registers the mid carry, the high operand halves, and the low result; stage 2 computes the high half, bout and OF into output registers.
REQ-017 An input beat is accepted when in_valid && in_ready are both 1; an output beat completes when out_valid && out_ready are both 1.
REQ-018 Latency SHALL be 2 cycles from acceptance to out_valid with no stall; throughput SHALL be 1 beat per cycle while out_ready stays 1.
REQ-019 Stage 2 advances when it is empty or its beat completes; stage 1 advances when it is empty or stage 2 advances.
REQ-020 in_ready SHALL equal "stage 1 empty or stage 1 advancing", and SHALL NOT depend combinationally on in_valid.
REQ-021 While out_valid=1 and out_ready=0, Diff, bout and OF SHALL hold stable.
REQ-022 Results SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-023 Simultaneous accept and output completion with both stages full SHALL shift the pipeline without a bubble.
REQ-024 Data registers SHALL load only when their stage advances with valid data.

Reset
REQ-025 On rst_n=0, both stage valid flags SHALL clear immediately; out_valid SHALL be 0; Diff, bout and OF SHALL be 0.
REQ-026 A reset mid-operation SHALL discard all in-flight beats.
REQ-027 in_ready SHALL be 1 from the first cycle after rst_n deasserts.

Structure
REQ-028 A shared package SHALL hold the slice width constant (4) and the stage count constant (2).
REQ-029 The carry-look-ahead slice SHALL be the existing 4-bit module carry_look_ahead_4bit, instantiated WIDTH/8 times per stage; no other sub-module.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=32):
- A=5, B=3, bin=0 -> Diff=0x00000002, bout=0, OF=0; out_valid 2 cycles after accept.
- A=7, B=2, bin=1 -> Diff=4.
- A=0, B=1, bin=0 -> Diff=0xFFFFFFFF, bout=1, OF=0.
- A=0x80000000, B=1 -> Diff=0x7FFFFFFF, bout=0, OF=1.
- A=0x00010000, B=1 -> Diff=0x0000FFFF; exercises a borrow across the stage boundary.
- Stall: 3 back-to-back beats with out_ready=0 for 4 cycles -> in_ready drops after 2 beats are held; outputs stay stable; all 3 beats emerge in order once out_ready=1.
- Reset: rst_n pulsed low with 2 beats in flight -> out_valid=0 at once; no stale beat appears after release.

Source files
------------

// File: rtl/cla_sub_pipe_32bit_pkg.sv
// Shared constants and helpers for the pipelined carry-look-ahead subtractor.
package cla_sub_pipe_32bit_pkg;

  localparam int SLICE_W    = 4;
  localparam int NUM_STAGES = 2;

  // Signed overflow of a - b: operand signs differ and the result sign differs from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/carry_look_ahead_4bit.sv
// 4-bit carry-look-ahead adder slice: sum = a + b + cin with all carries
// formed directly from generate/propagate terms.
module carry_look_ahead_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g_s;
  logic [3:0] p_s;
  logic [4:0] c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  assign c_s[0] = cin;
  assign c_s[1] = g_s[0] | (p_s[0] & cin);
  assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & cin);
  assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                | (p_s[2] & p_s[1] & p_s[0] & cin);
  assign c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & cin);

  assign sum  = p_s ^ c_s[3:0];
  assign cout = c_s[4];

endmodule

// File: rtl/cla_sub_pipe_32bit.sv
// Two-stage pipelined subtractor Diff = A - B - bin built from 4-bit CLA slices,
// low half in stage 1, high half plus flags in stage 2, valid/ready handshake.
module cla_sub_pipe_32bit
  import cla_sub_pipe_32bit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             bout,
  output logic             OF
);

  localparam int HALF = WIDTH / 2;
  localparam int NSL  = HALF / SLICE_W;

  logic             s1_valid_r;
  logic [HALF-1:0]  s1_a_hi_r;
  logic [HALF-1:0]  s1_b_hi_r;
  logic [HALF-1:0]  s1_lo_r;
  logic             s1_carry_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] diff_r;
  logic             bout_r;
  logic             of_r;

  logic             s1_adv_s;
  logic             s2_adv_s;
  logic             accept_s;

  logic [WIDTH-1:0] b_inv_s;
  logic [NSL:0]     c1_s;
  logic [HALF-1:0]  lo_s;
  logic [HALF-1:0]  b_hi_inv_s;
  logic [NSL:0]     c2_s;
  logic [HALF-1:0]  hi_s;

  assign s2_adv_s = ~s2_valid_r | out_ready;
  assign s1_adv_s = ~s1_valid_r | s2_adv_s;
  assign accept_s = in_valid & s1_adv_s;

  assign in_ready  = s1_adv_s;
  assign out_valid = s2_valid_r;
  assign Diff      = diff_r;
  assign bout      = bout_r;
  assign OF        = of_r;

  // Subtraction as A + ~B + ~bin; the inverted borrow-in is the initial carry.
  assign b_inv_s    = ~B;
  assign c1_s[0]    = ~bin;
  assign b_hi_inv_s = ~s1_b_hi_r;
  assign c2_s[0]    = s1_carry_r;

  for (genvar i = 0; i < NSL; i++) begin : g_lo
    carry_look_ahead_4bit u_cla (
      .a    (A[i*SLICE_W +: SLICE_W]),
      .b    (b_inv_s[i*SLICE_W +: SLICE_W]),
      .cin  (c1_s[i]),
      .sum  (lo_s[i*SLICE_W +: SLICE_W]),
      .cout (c1_s[i+1])
    );
  end

  for (genvar i = 0; i < NSL; i++) begin : g_hi
    carry_look_ahead_4bit u_cla (
      .a    (s1_a_hi_r[i*SLICE_W +: SLICE_W]),
      .b    (b_hi_inv_s[i*SLICE_W +: SLICE_W]),
      .cin  (c2_s[i]),
      .sum  (hi_s[i*SLICE_W +: SLICE_W]),
      .cout (c2_s[i+1])
    );
  end

  // Stage valid flags: each stage takes its upstream valid whenever it advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (s1_adv_s) s1_valid_r <= in_valid;
      if (s2_adv_s) s2_valid_r <= s1_valid_r;
    end
  end

  // Stage 1 data: low result, mid carry and the untouched high operand halves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_a_hi_r  <= {HALF{1'b0}};
      s1_b_hi_r  <= {HALF{1'b0}};
      s1_lo_r    <= {HALF{1'b0}};
      s1_carry_r <= 1'b0;
    end else if (accept_s) begin
      s1_a_hi_r  <= A[WIDTH-1:HALF];
      s1_b_hi_r  <= B[WIDTH-1:HALF];
      s1_lo_r    <= lo_s;
      s1_carry_r <= c1_s[NSL];
    end
  end

  // Output registers: hold while a result is offered but not taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_r <= {WIDTH{1'b0}};
      bout_r <= 1'b0;
      of_r   <= 1'b0;
    end else if (s2_adv_s && s1_valid_r) begin
      diff_r <= {hi_s, s1_lo_r};
      bout_r <= ~c2_s[NSL];
      of_r   <= sub_overflow(s1_a_hi_r[HALF-1], s1_b_hi_r[HALF-1], hi_s[HALF-1]);
    end
  end

endmodule
